// File: rtl/wts_pkg.sv
// Shared encodings for the per-channel key event sequencer.
package wts_pkg;

    typedef enum logic [1:0] {
        WTS_CMD_NOP     = 2'd0,
        WTS_CMD_ON      = 2'd1,
        WTS_CMD_RELEASE = 2'd2,
        WTS_CMD_OFF     = 2'd3
    } wts_cmd_e;

    typedef enum logic [1:0] {
        WTS_KS_IDLE    = 2'd0,
        WTS_KS_GATE    = 2'd1,
        WTS_KS_RELEASE = 2'd2
    } wts_ks_state_e;

endpackage

// File: rtl/wts_gate_timer.sv
// Prescaled gate down-counter; expire flags the tick that takes the count from 1 to 0.
module wts_gate_timer #(
    parameter int PRESCALE_BITS = 4,
    parameter int GATE_BITS     = 12
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 load,
    input  logic [GATE_BITS-1:0] load_value,
    input  logic                 tick,
    output logic                 expire
);

    localparam logic [PRESCALE_BITS-1:0] PRESCALE_MAX = {PRESCALE_BITS{1'b1}};
    localparam logic [GATE_BITS-1:0]     GATE_ONE     = GATE_BITS'(1);

    logic [PRESCALE_BITS-1:0] prescale_r;
    logic [GATE_BITS-1:0]     count_r;
    logic                     wrap_s;

    assign wrap_s = tick && (prescale_r == PRESCALE_MAX);
    // Load has priority, so a key on at the expiry tick restarts the gate cleanly.
    assign expire = wrap_s && !load && (count_r == GATE_ONE);

    // Prescaler and gate counter; a zero count stays parked at zero.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            prescale_r <= '0;
            count_r    <= '0;
        end else if (load) begin
            prescale_r <= '0;
            count_r    <= load_value;
        end else if (tick) begin
            prescale_r <= prescale_r + PRESCALE_BITS'(1);
            if (wrap_s && (count_r != '0)) begin
                count_r <= count_r - GATE_ONE;
            end else begin
                count_r <= count_r;
            end
        end else begin
            prescale_r <= prescale_r;
            count_r    <= count_r;
        end
    end

endmodule

// File: rtl/wts_key_sequencer.sv
// Converts CPU key commands into active-aligned key pulses for one ADSR channel.
module wts_key_sequencer
    import wts_pkg::*;
#(
    parameter int PRESCALE_BITS = 4,
    parameter int GATE_BITS     = 12
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 active,
    input  logic                 reg_write,
    input  logic [1:0]           reg_cmd,
    input  logic [GATE_BITS-1:0] reg_gate,
    input  logic [7:0]           envelope,
    output logic                 key_on,
    output logic                 key_release,
    output logic                 key_off,
    output logic                 busy,
    output logic [1:0]           state
);

    wts_ks_state_e        state_r, state_n;
    logic                 pend_valid_r, pend_valid_n;
    wts_cmd_e             pend_cmd_r, pend_cmd_n;
    logic [GATE_BITS-1:0] pend_gate_r, pend_gate_n;
    logic                 key_on_r, key_release_r, key_off_r, busy_r;
    logic                 consume_s, load_s, tick_s, expire_s, auto_rel_s;

    assign consume_s  = active && pend_valid_r;
    assign load_s     = consume_s && (pend_cmd_r == WTS_CMD_ON);
    assign tick_s     = active && (state_r == WTS_KS_GATE);
    assign auto_rel_s = expire_s && !pend_valid_r;

    wts_gate_timer #(
        .PRESCALE_BITS (PRESCALE_BITS),
        .GATE_BITS     (GATE_BITS)
    ) u_gate_timer (
        .clk        (clk),
        .nreset     (nreset),
        .load       (load_s),
        .load_value (pend_gate_r),
        .tick       (tick_s),
        .expire     (expire_s)
    );

    // Next state: consume at active first, then auto-release, then a CPU write wins.
    always_comb begin
        state_n      = state_r;
        pend_valid_n = pend_valid_r;
        pend_cmd_n   = pend_cmd_r;
        pend_gate_n  = pend_gate_r;
        if (consume_s) begin
            pend_valid_n = 1'b0;
            case (pend_cmd_r)
                WTS_CMD_ON:  state_n = WTS_KS_GATE;
                WTS_CMD_OFF: state_n = WTS_KS_IDLE;
                WTS_CMD_RELEASE: begin
                    if (state_r == WTS_KS_GATE) begin
                        state_n = WTS_KS_RELEASE;
                    end else begin
                        state_n = state_r;
                    end
                end
                default:     state_n = state_r;
            endcase
        end else if (active && (state_r == WTS_KS_RELEASE) && (envelope == 8'd0)) begin
            state_n = WTS_KS_IDLE;
        end else begin
            state_n = state_r;
        end
        if (auto_rel_s) begin
            pend_valid_n = 1'b1;
            pend_cmd_n   = WTS_CMD_RELEASE;
        end else begin
            pend_cmd_n   = pend_cmd_n;
        end
        if (reg_write && (reg_cmd != 2'd0)) begin
            pend_valid_n = 1'b1;
            pend_cmd_n   = wts_cmd_e'(reg_cmd);
            pend_gate_n  = reg_gate;
        end else begin
            pend_gate_n  = pend_gate_n;
        end
    end

    // State, pending command and registered pulse/busy outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r       <= WTS_KS_IDLE;
            pend_valid_r  <= 1'b0;
            pend_cmd_r    <= WTS_CMD_NOP;
            pend_gate_r   <= '0;
            key_on_r      <= 1'b0;
            key_release_r <= 1'b0;
            key_off_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_n;
            pend_valid_r  <= pend_valid_n;
            pend_cmd_r    <= pend_cmd_n;
            pend_gate_r   <= pend_gate_n;
            key_on_r      <= pend_valid_n && (pend_cmd_n == WTS_CMD_ON);
            key_release_r <= pend_valid_n && (pend_cmd_n == WTS_CMD_RELEASE);
            key_off_r     <= pend_valid_n && (pend_cmd_n == WTS_CMD_OFF);
            busy_r        <= (state_n != WTS_KS_IDLE) || pend_valid_n;
        end
    end

    assign key_on      = key_on_r;
    assign key_release = key_release_r;
    assign key_off     = key_off_r;
    assign busy        = busy_r;
    assign state       = state_r;

endmodule

// File: tb/tb_wts_key_sequencer.sv
// Scoreboard bench: expected pulse codes are queued at stimulus and popped when a pulse meets active.
module tb_wts_key_sequencer;

    logic        clk = 1'b0;
    logic        nreset;
    logic        active;
    logic        reg_write;
    logic [1:0]  reg_cmd;
    logic [11:0] reg_gate;
    logic [7:0]  envelope;
    logic        key_on, key_release, key_off, busy;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];

    wts_key_sequencer #(.PRESCALE_BITS(4), .GATE_BITS(12)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .active      (active),
        .reg_write   (reg_write),
        .reg_cmd     (reg_cmd),
        .reg_gate    (reg_gate),
        .envelope    (envelope),
        .key_on      (key_on),
        .key_release (key_release),
        .key_off     (key_off),
        .busy        (busy),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] c, input logic [11:0] g);
        reg_cmd   = c;
        reg_gate  = g;
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        reg_cmd   = 2'd0;
    endtask

    task automatic act(input int n);
        for (int i = 0; i < n; i++) begin
            active = 1'b1;
            tick();
            active = 1'b0;
            tick();
            tick();
        end
    endtask

    // A pulse seen with active high is consumed at the coming edge; compare it against the queue.
    always @(negedge clk) begin
        if (nreset && active && (key_on || key_release || key_off)) begin
            logic [1:0] code;
            code = key_on ? 2'd1 : (key_release ? 2'd2 : 2'd3);
            check_val("onehot", int'(key_on) + int'(key_release) + int'(key_off), 1);
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse", code, 0);
            end else begin
                check_val("pulse_order", code, exp_q.pop_front());
            end
        end
    end

    initial begin
        nreset = 1'b0; active = 1'b0; reg_write = 1'b0;
        reg_cmd = 2'd0; reg_gate = 12'd0; envelope = 8'd100;
        repeat (3) tick();
        check_val("rst_state", state, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_keys", {key_on, key_release, key_off}, 0);
        nreset = 1'b1;
        tick();

        // Auto-release after 2*16 actives.
        exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        wr(2'd1, 12'd2);
        check_val("on_latency", key_on, 1);
        check_val("on_busy", busy, 1);
        act(1);
        check_val("on_cleared", key_on, 0);
        check_val("on_state", state, 1);
        act(31);
        check_val("gate_early", key_release, 0);
        act(1);
        check_val("auto_rel_issued", key_release, 1);
        check_val("auto_rel_state_pre", state, 1);
        act(1);
        check_val("auto_rel_state", state, 2);
        check_val("auto_rel_cleared", key_release, 0);
        envelope = 8'd0;
        act(1);
        check_val("decay_idle", state, 0);
        check_val("decay_busy", busy, 0);

        // Gate 0: manual release only.
        envelope = 8'd100;
        exp_q.push_back(2'd1);
        wr(2'd1, 12'd0);
        act(1001);
        check_val("gate0_state", state, 1);
        check_val("gate0_norel", key_release, 0);

        // Manual release held by a non-decaying envelope, then key off.
        exp_q.push_back(2'd2);
        wr(2'd2, 12'd0);
        act(1);
        check_val("man_rel_state", state, 2);
        envelope = 8'd40;
        act(20);
        check_val("hold_release", state, 2);
        exp_q.push_back(2'd3);
        wr(2'd3, 12'd0);
        check_val("off_pulse", key_off, 1);
        act(1);
        check_val("off_state", state, 0);
        check_val("off_norel", key_release, 0);

        // Overwrite: on then off before any active.
        exp_q.push_back(2'd3);
        wr(2'd1, 12'd5);
        wr(2'd3, 12'd0);
        check_val("ovr_key_off", key_off, 1);
        check_val("ovr_key_on", key_on, 0);
        act(1);
        check_val("ovr_state", state, 0);

        // CPU key on pending at the expiry tick suppresses the auto-release and reloads the gate.
        exp_q.push_back(2'd1);
        wr(2'd1, 12'd1);
        act(16);
        exp_q.push_back(2'd1);
        wr(2'd1, 12'd3);
        act(1);
        check_val("sup_state", state, 1);
        check_val("sup_norel", key_release, 0);
        exp_q.push_back(2'd2);
        act(47);
        check_val("reload_early", key_release, 0);
        act(1);
        check_val("reload_expire", key_release, 1);
        act(1);
        check_val("reload_state", state, 2);
        exp_q.push_back(2'd3);
        wr(2'd3, 12'd0);
        act(1);
        check_val("reload_off", state, 0);

        // Asynchronous reset mid-pulse.
        wr(2'd1, 12'd2);
        check_val("pre_rst_on", key_on, 1);
        #2;
        nreset = 1'b0;
        #1;
        check_val("async_keys", {key_on, key_release, key_off}, 0);
        check_val("async_busy", busy, 0);
        #3;
        nreset = 1'b1;
        tick();
        tick();
        check_val("post_rst_state", state, 0);
        check_val("post_rst_busy", busy, 0);

        check_val("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wts_key_sequencer.md
Name: wts_key_sequencer

Overview:
Per-channel key event source that drives the key_on/key_release/key_off pulse inputs of the channel's ADSR envelope generator. Converts CPU register key commands into pulses aligned to the 3.579MHz active strobe. Runs an optional gate-time counter that issues an automatic key_release. Monitors the returned envelope level to report channel busy.

Parameters:
PRESCALE_BITS, 4, gate counter advances once per 2^PRESCALE_BITS active pulses
GATE_BITS, 12, width of the gate-length register

Ports:
clk  input  1  system clock
nreset  input  1  asynchronous reset, active-low
active  input  1  3.579MHz timing pulse, one clk wide
reg_write  input  1  one-clk strobe: reg_cmd/reg_gate valid
reg_cmd  input  2  0:nop, 1:key on, 2:key release, 3:key off
reg_gate  input  GATE_BITS  gate length in prescaled ticks; 0 = manual release only
envelope  input  8  current envelope level from the generator (0..128)
key_on  output  1  pulse to envelope generator
key_release  output  1  pulse to envelope generator
key_off  output  1  pulse to envelope generator
busy  output  1  1 while the note is sounding or a pulse is pending
state  output  2  0:IDLE, 1:GATE, 2:RELEASE

Behaviour:
- Reset: state=IDLE, key_on/key_release/key_off=0, busy=0, gate and prescale counters=0, pending=none.
- Pending register: holds at most one command. reg_write with cmd!=0 loads it, overwriting any unconsumed command; the last write wins. reg_write with cmd=0 is ignored.
- Pulse issue: key_* outputs are registered. The matching output is 1 from the clk edge after pending is loaded. It stays 1 until the first clk edge at which active=1, then clears on that edge.
- The envelope generator therefore sees exactly one active-qualified pulse. At most one key_* output is 1 at any time.
- Latency: command write to output high is 1 clk. The pulse is consumed at the next active.
- FSM transitions take effect at the consuming active edge:
  - key on, any state -> GATE. Gate counter loads reg_gate as latched at write; prescaler clears.
  - key release in GATE -> RELEASE.
  - key release in IDLE or RELEASE -> pulse still issued; state unchanged.
  - key off, any state -> IDLE.
- GATE:
  - Each active increments the prescaler. On prescaler wrap, a nonzero gate counter decrements.
  - When the counter reaches 0 from 1, an internal auto-release is queued only if pending is empty. It issues key_release like a CPU command. State -> RELEASE when it is consumed.
  - A CPU command pending at that moment suppresses the auto-release.
  - Gate 0 at key on: no auto-release.
- RELEASE: at an active with envelope==0 and no pending command -> IDLE. An envelope that never decays holds RELEASE until key on or key off.
- Envelope is ignored in GATE; the attack starts from 0.
- busy = (state!=IDLE) | pending valid | any key_* high.
- Simultaneous: reg_write on the same clk as a consuming active edge is loaded after the consume. The new command issues on the next clk and is not lost.
- Reset mid-pulse: all outputs drop immediately (asynchronous).

Decomposition:
- Shared package wts_pkg holds:
  - command encodings WTS_CMD_NOP/ON/RELEASE/OFF.
  - state encodings WTS_KS_IDLE/GATE/RELEASE.
- One natural sub-module, wts_gate_timer: the prescaler plus gate down-counter, with load, tick(active), and expire outputs.
- The FSM and pending/pulse logic stay in the top.

Test Plan:
- Reset, then key on with gate=2, active every 3 clk:
  - key_on high 1 clk after the write, cleared at the first active; state=GATE.
  - After 2*16 actives, key_release is issued; state=RELEASE.
  - Force envelope 0 -> IDLE; busy=0.
- Key on with gate=0, hold 1000 actives -> no key_release; state stays GATE.
- Manual: CPU release -> key_release, state=RELEASE. Envelope 40 held -> stays RELEASE. Key off -> key_off pulse, state=IDLE, no key_release.
- Two writes (on, then off) before any active -> only key_off is ever asserted; state=IDLE.
- CPU key on pending at the clk the gate expires -> key_on issued, no auto key_release; gate reloaded.
- Assert nreset low while key_on is high -> all outputs 0 at once; after release, state=IDLE and busy=0.
